// File: rtl/fifo_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fifo_pkg : shared defaults and state encoding for fifo_rd_packer      |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package fifo_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_LANES = 4;

  typedef enum logic [1:0] {
    FILL     = 2'd0,
    COMPLETE = 2'd1,
    FLUSH    = 2'd2
  } state_e;

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/fifo_word_outreg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fifo_word_outreg : single output word register with valid/ready hold  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module fifo_word_outreg
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LANES = DEF_LANES
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   load_i,
  input  logic [WIDTH*LANES-1:0] data_i,
  input  logic [LANES-1:0]       keep_i,
  input  logic                   ready_i,
  output logic [WIDTH*LANES-1:0] word_o,
  output logic [LANES-1:0]       keep_o,
  output logic                   valid_o,
  output logic                   free_o
);

  logic [WIDTH*LANES-1:0] word_q, word_d;
  logic [LANES-1:0]       keep_q, keep_d;
  logic                   valid_q, valid_d;

  // A load wins over a same-cycle transfer, so valid stays high with the new word.
  always_comb begin
    word_d  = word_q;
    keep_d  = keep_q;
    valid_d = valid_q && !ready_i;
    if (load_i) begin
      word_d  = data_i;
      keep_d  = keep_i;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      word_q  <= '0;
      keep_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      word_q  <= word_d;
      keep_q  <= keep_d;
      valid_q <= valid_d;
    end
  end

  assign word_o  = word_q;
  assign keep_o  = keep_q;
  assign valid_o = valid_q;
  assign free_o  = !valid_q || ready_i;

endmodule : fifo_word_outreg
`default_nettype wire

// File: rtl/fifo_rd_packer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fifo_rd_packer : reads FIFO entries and packs LANES of them per word  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module fifo_rd_packer
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LANES = DEF_LANES
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   fifo_empty_i,
  input  logic [WIDTH-1:0]       fifo_rdata_i,
  input  logic                   fifo_rd_error_i,
  output logic                   fifo_rd_en_o,
  input  logic                   flush_i,
  output logic [WIDTH*LANES-1:0] word_o,
  output logic [LANES-1:0]       word_keep_o,
  output logic                   word_valid_o,
  input  logic                   word_ready_i,
  output logic                   err_o
);

  localparam int               CNT_W    = $clog2(LANES + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(LANES);

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   pend_q, pend_d;
  logic [WIDTH*LANES-1:0] lanes_q, lanes_d;
  logic                   err_q;

  logic [CNT_W-1:0]       w_cnt_cap;
  logic [WIDTH*LANES-1:0] w_lanes_cap;
  logic [WIDTH*LANES-1:0] w_out_data;
  logic [LANES-1:0]       w_out_keep;
  logic                   w_free;
  logic                   w_load;
  logic                   w_flush_hold;
  logic                   w_cap_full;
  logic                   w_flush_req;
  logic                   w_rd_en;

  // View of the assembly after this cycle's in-flight entry lands.
  assign w_cnt_cap = cnt_q + CNT_W'(pend_q);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign w_lanes_cap[i*WIDTH +: WIDTH] = (pend_q && (cnt_q == CNT_W'(i)))
                                         ? fifo_rdata_i
                                         : lanes_q[i*WIDTH +: WIDTH];
    assign w_out_keep[i]                = CNT_W'(i) < w_cnt_cap;
    assign w_out_data[i*WIDTH +: WIDTH] = w_out_keep[i] ? w_lanes_cap[i*WIDTH +: WIDTH]
                                                        : '0;
  end

  assign w_cap_full  = pend_q && (w_cnt_cap == FULL_CNT);
  assign w_flush_req = flush_i && ((cnt_q != '0) || pend_q);

  // State register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FILL: begin
        if (w_cap_full) begin
          state_d = w_free ? FILL : COMPLETE;
        end else if (w_flush_req) begin
          state_d = (pend_q || !w_free) ? FLUSH : FILL;
        end
      end
      COMPLETE,
      FLUSH: begin
        if (w_free) state_d = FILL;
      end
      default: state_d = FILL;
    endcase
  end

  // Output logic: emission strobe and read blocking during a flush
  always_comb begin
    w_load       = 1'b0;
    w_flush_hold = 1'b0;
    unique case (state_q)
      FILL: begin
        if (w_cap_full) begin
          w_load = w_free;
        end else if (w_flush_req) begin
          w_flush_hold = 1'b1;
          w_load       = !pend_q && w_free;
        end
      end
      COMPLETE: w_load = w_free;
      FLUSH: begin
        w_flush_hold = 1'b1;
        w_load       = w_free;
      end
      default: w_load = 1'b0;
    endcase
  end

  assign w_rd_en = rst_n_i && !fifo_empty_i && (w_cnt_cap < FULL_CNT) && !w_flush_hold;

  always_comb begin
    pend_d  = w_rd_en;
    cnt_d   = w_load ? '0 : w_cnt_cap;
    lanes_d = w_load ? '0 : w_lanes_cap;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      lanes_q <= '0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      lanes_q <= lanes_d;
      err_q   <= err_q || fifo_rd_error_i;
    end
  end

  fifo_word_outreg #(
    .WIDTH (WIDTH),
    .LANES (LANES)
  ) u_outreg (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .load_i  (w_load),
    .data_i  (w_out_data),
    .keep_i  (w_out_keep),
    .ready_i (word_ready_i),
    .word_o  (word_o),
    .keep_o  (word_keep_o),
    .valid_o (word_valid_o),
    .free_o  (w_free)
  );

  assign fifo_rd_en_o = w_rd_en;
  assign err_o        = err_q;

endmodule : fifo_rd_packer
`default_nettype wire

// File: tb/tb_fifo_rd_packer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fifo_rd_packer : FIFO model + word scoreboard for fifo_rd_packer   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_fifo_rd_packer;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        fifo_empty_i;
  logic [7:0]  fifo_rdata_i;
  logic        fifo_rd_error_i;
  logic        fifo_rd_en_o;
  logic        flush_i;
  logic [31:0] word_o;
  logic [3:0]  word_keep_o;
  logic        word_valid_o;
  logic        word_ready_i;
  logic        err_o;

  fifo_rd_packer #(.WIDTH(8), .LANES(4)) dut (
    .clk_i           (clk_i),
    .rst_n_i         (rst_n_i),
    .fifo_empty_i    (fifo_empty_i),
    .fifo_rdata_i    (fifo_rdata_i),
    .fifo_rd_error_i (fifo_rd_error_i),
    .fifo_rd_en_o    (fifo_rd_en_o),
    .flush_i         (flush_i),
    .word_o          (word_o),
    .word_keep_o     (word_keep_o),
    .word_valid_o    (word_valid_o),
    .word_ready_i    (word_ready_i),
    .err_o           (err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] w;
    logic [3:0]  k;
  } wexp_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [7:0]  fq[$];
  logic [7:0]  cur[$];
  wexp_t       exp_q[$];
  logic        exp_err = 1'b0;
  logic [31:0] s_word;
  logic [3:0]  s_keep;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entries read since the last boundary form the next word, lane 0 first.
  function automatic void close_word();
    wexp_t e;
    int    n;
    n   = cur.size();
    e.w = '0;
    for (int i = 0; i < n; i++) e.w[i*8 +: 8] = cur[i];
    e.k = 4'((1 << n) - 1);
    exp_q.push_back(e);
    cur.delete();
  endfunction

  // Called at a falling edge; returns at the next falling edge.
  task automatic run_cycle(input bit push, input logic [7:0] val, input bit rdy,
                           input bit fl, input bit er, output bit rd, output bit vld);
    logic  s_valid;
    wexp_t e;
    if (push) fq.push_back(val);
    fifo_empty_i    = (fq.size() == 0);
    word_ready_i    = rdy;
    flush_i         = fl;
    fifo_rd_error_i = er;
    #1;
    rd      = fifo_rd_en_o;
    s_valid = word_valid_o;
    vld     = s_valid;
    s_word  = word_o;
    s_keep  = word_keep_o;
    chk("rd_en_while_empty", 64'(rd && fifo_empty_i), 64'd0);
    if (fl && cur.size() > 0) close_word();
    if (s_valid && rdy) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_word", 64'(s_word), 64'hDEAD_BEEF_0000);
      end else begin
        e = exp_q.pop_front();
        chk("word_data", 64'(s_word), 64'(e.w));
        chk("word_keep", 64'(s_keep), 64'(e.k));
      end
    end
    if (er) exp_err = 1'b1;
    @(posedge clk_i);
    #1;
    if (rd && fq.size() > 0) begin
      fifo_rdata_i = fq.pop_front();
      cur.push_back(fifo_rdata_i);
      if (cur.size() == 4) close_word();
    end
    fifo_empty_i = (fq.size() == 0);
    chk("err_sticky", 64'(err_o), 64'(exp_err));
    if (s_valid && !rdy) begin
      chk("hold_valid", 64'(word_valid_o), 64'd1);
      chk("hold_word",  64'(word_o),       64'(s_word));
      chk("hold_keep",  64'(word_keep_o),  64'(s_keep));
    end
    fifo_rd_error_i = 1'b0;
    flush_i         = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    rst_n_i = 1'b0;
    #1;
    chk("rst_valid", 64'(word_valid_o), 64'd0);
    chk("rst_word",  64'(word_o),       64'd0);
    chk("rst_keep",  64'(word_keep_o),  64'd0);
    chk("rst_err",   64'(err_o),        64'd0);
    chk("rst_rd_en", 64'(fifo_rd_en_o), 64'd0);
    @(negedge clk_i);
    @(negedge clk_i);
    fq.delete();
    cur.delete();
    exp_q.delete();
    exp_err      = 1'b0;
    fifo_empty_i = 1'b1;
    rst_n_i      = 1'b1;
  endtask

  task automatic drain();
    bit rd, v;
    for (int c = 0; c < 8; c++) run_cycle(0, 8'h0, 1, 0, 0, rd, v);
    run_cycle(0, 8'h0, 1, 1, 0, rd, v);
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) run_cycle(0, 8'h0, 1, 0, 0, rd, v);
    run_cycle(0, 8'h0, 1, 0, 0, rd, v);
    chk("drain_words_left",   64'(exp_q.size()), 64'd0);
    chk("drain_entries_left", 64'(cur.size()),   64'd0);
  endtask

  initial begin
    bit          rd, v;
    logic [7:0]  pre[12];
    rst_n_i         = 1'b0;
    fifo_empty_i    = 1'b1;
    fifo_rdata_i    = '0;
    fifo_rd_error_i = 1'b0;
    flush_i         = 1'b0;
    word_ready_i    = 1'b0;
    @(negedge clk_i);
    do_reset();

    // Full word latency with ready held high
    fq.push_back(8'h11); fq.push_back(8'h22); fq.push_back(8'h33); fq.push_back(8'h44);
    for (int c = 0; c < 6; c++) begin
      run_cycle(0, 8'h0, 1, 0, 0, rd, v);
      chk($sformatf("lat_rd_c%0d", c), 64'(rd), 64'(c < 4));
      if (c >= 4) chk($sformatf("lat_valid_c%0d", c), 64'(v), 64'(c == 5));
    end
    chk("lat_word", 64'(s_word), 64'h4433_2211);
    chk("lat_keep", 64'(s_keep), 64'hF);
    drain();

    // Backpressure: first word held, reads stop once assembly is full
    do_reset();
    pre = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
            8'h99, 8'hAA, 8'hBB, 8'hCC};
    foreach (pre[i]) fq.push_back(pre[i]);
    for (int c = 0; c < 12; c++) run_cycle(0, 8'h0, 0, 0, 0, rd, v);
    chk("bp_rd_stopped",  64'(rd),        64'd0);
    chk("bp_entries_read", 64'(fq.size()), 64'd4);
    chk("bp_valid",       64'(v),         64'd1);
    chk("bp_word",        64'(s_word),    64'h4433_2211);
    for (int c = 0; c < 14; c++) run_cycle(0, 8'h0, 1, 0, 0, rd, v);
    chk("bp_all_emitted", 64'(exp_q.size()), 64'd0);
    drain();

    // Flush with nothing in flight
    do_reset();
    fq.push_back(8'hAA); fq.push_back(8'hBB);
    for (int c = 0; c < 4; c++) run_cycle(0, 8'h0, 1, 0, 0, rd, v);
    run_cycle(0, 8'h0, 1, 1, 0, rd, v);
    run_cycle(0, 8'h0, 1, 0, 0, rd, v);
    chk("flush_valid", 64'(v),      64'd1);
    chk("flush_word",  64'(s_word), 64'h0000_BBAA);
    chk("flush_keep",  64'(s_keep), 64'h3);
    drain();

    // Flush while an entry is in flight
    do_reset();
    fq.push_back(8'h01); fq.push_back(8'h02); fq.push_back(8'h03);
    run_cycle(0, 8'h0, 1, 0, 0, rd, v);
    run_cycle(0, 8'h0, 1, 1, 0, rd, v);
    chk("fpend_rd_blocked", 64'(rd), 64'd0);
    run_cycle(0, 8'h0, 1, 0, 0, rd, v);
    chk("fpend_rd_held", 64'(rd), 64'd0);
    run_cycle(0, 8'h0, 1, 0, 0, rd, v);
    chk("fpend_valid", 64'(v),      64'd1);
    chk("fpend_word",  64'(s_word), 64'h0000_0001);
    chk("fpend_keep",  64'(s_keep), 64'h1);
    drain();

    // Error is sticky; reset mid-word clears everything
    run_cycle(0, 8'h0, 1, 0, 1, rd, v);
    for (int c = 0; c < 3; c++) run_cycle(0, 8'h0, 1, 0, 0, rd, v);
    chk("err_set", 64'(err_o), 64'd1);
    fq.push_back(8'h5A); fq.push_back(8'hA5); fq.push_back(8'h3C);
    fq.push_back(8'hC3); fq.push_back(8'h77);
    for (int c = 0; c < 2; c++) run_cycle(0, 8'h0, 0, 0, 0, rd, v);
    do_reset();
    for (int c = 0; c < 4; c++) run_cycle(0, 8'h0, 1, 0, 0, rd, v);
    chk("post_rst_no_word", 64'(v), 64'd0);

    // Randomized traffic against the scoreboard
    for (int c = 0; c < 1500; c++) begin
      run_cycle($urandom_range(0, 9) < 6, 8'($urandom), $urandom_range(0, 9) < 7,
                $urandom_range(0, 19) == 0, $urandom_range(0, 199) == 0, rd, v);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_fifo_rd_packer
`default_nettype wire
